// File: rtl/fullcalc_cu.sv
`default_nettype none
// ============================================================================
//  Module      : fullcalc_cu
//  Description : Moore control unit sequencing the FullCalc datapath
//                (load, decode, Calc/MUL/DIV wait, store, go/done handshake).
//                FULLCALC_TIMEOUT_EN enables the Calc/DIV wait timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module fullcalc_cu #(
    parameter int MUL_LAT = 1,
    parameter int TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       go,
    input  logic [2:0] qF,
    input  logic       Done_Calc,
    input  logic       Done_DIV,
    output logic       En_F,
    output logic       En_X,
    output logic       En_Y,
    output logic       Go_Calc,
    output logic       Go_DIV,
    output logic [1:0] Op_Calc,
    output logic [1:0] Sel_L,
    output logic       Sel_H,
    output logic       En_out_L,
    output logic       En_out_H,
    output logic       done,
    output logic       err,
    output logic [3:0] cs
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_LOAD   = 4'd1,
        S_DECODE = 4'd2,
        S_CALC   = 4'd3,
        S_MUL    = 4'd4,
        S_DIV    = 4'd5,
        S_STORE  = 4'd6,
        S_DONE   = 4'd7,
        S_ERR    = 4'd8
    } state_t;

    if (MUL_LAT < 1 || MUL_LAT > 7) begin : g_bad_mul_lat
        $error("fullcalc_cu: MUL_LAT must be 1..7");
    end
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("fullcalc_cu: TIMEOUT must be 1..255");
    end

    localparam logic [2:0] c_MUL_LOAD = 3'(MUL_LAT - 1);

    state_t     r_state;
    state_t     w_next;
    logic [2:0] r_mul_cnt;
    logic [1:0] r_op_calc;
    logic [1:0] r_sel_l;
    logic       r_sel_h;
    logic       r_wide;
    logic [1:0] w_op_calc;
    logic [1:0] w_sel_l;
    logic       w_timeout;

`ifdef FULLCALC_TIMEOUT_EN
    localparam logic [7:0] c_TIMER_LAST = 8'(TIMEOUT - 1);
    logic [7:0] r_timer;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_timer <= 8'd0;
        end else if (r_state == S_DECODE) begin
            r_timer <= 8'd0;
        end else if (r_state == S_CALC || r_state == S_DIV) begin
            r_timer <= r_timer + 8'd1;
        end
    end

    // Fires during the TIMEOUT-th wait cycle; a simultaneous done still wins.
    assign w_timeout = (r_timer == c_TIMER_LAST);
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_op_calc = 2'd0;
        w_sel_l   = 2'd0;
        case (qF)
            3'd1, 3'd2, 3'd3, 3'd4: begin
                w_op_calc = 2'(qF - 3'd1);
                w_sel_l   = 2'd1;
            end
            3'd5:    w_sel_l = 2'd2;
            3'd6:    w_sel_l = 2'd3;
            default: w_sel_l = 2'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_mul_cnt <= 3'd0;
            r_op_calc <= 2'd0;
            r_sel_l   <= 2'd0;
            r_sel_h   <= 1'b0;
            r_wide    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) begin
                r_mul_cnt <= c_MUL_LOAD;
                r_op_calc <= w_op_calc;
                r_sel_l   <= w_sel_l;
                r_sel_h   <= (qF == 3'd6);
                r_wide    <= (qF == 3'd5) || (qF == 3'd6);
            end else if (r_state == S_MUL && r_mul_cnt != 3'd0) begin
                r_mul_cnt <= r_mul_cnt - 3'd1;
            end
        end
    end

    always_comb begin
        w_next   = r_state;
        En_F     = 1'b0;
        En_X     = 1'b0;
        En_Y     = 1'b0;
        Go_Calc  = 1'b0;
        Go_DIV   = 1'b0;
        En_out_L = 1'b0;
        En_out_H = 1'b0;
        done     = 1'b0;
        err      = 1'b0;
        case (r_state)
            S_IDLE: if (go) w_next = S_LOAD;
            S_LOAD: begin
                En_F   = 1'b1;
                En_X   = 1'b1;
                En_Y   = 1'b1;
                w_next = S_DECODE;
            end
            S_DECODE: begin
                case (qF)
                    3'd0:                   w_next = S_STORE;
                    3'd1, 3'd2, 3'd3, 3'd4: w_next = S_CALC;
                    3'd5:                   w_next = S_MUL;
                    3'd6:                   w_next = S_DIV;
                    default:                w_next = S_ERR;
                endcase
            end
            S_CALC: begin
                Go_Calc = 1'b1;
                if (Done_Calc)      w_next = S_STORE;
                else if (w_timeout) w_next = S_ERR;
            end
            S_DIV: begin
                Go_DIV = 1'b1;
                if (Done_DIV)       w_next = S_STORE;
                else if (w_timeout) w_next = S_ERR;
            end
            S_MUL: if (r_mul_cnt == 3'd0) w_next = S_STORE;
            S_STORE: begin
                En_out_L = 1'b1;
                En_out_H = r_wide;
                w_next   = S_DONE;
            end
            S_DONE: begin
                done = 1'b1;
                if (!go) w_next = S_IDLE;
            end
            S_ERR: begin
                err = 1'b1;
                if (!go) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign Op_Calc = r_op_calc;
    assign Sel_L   = r_sel_l;
    assign Sel_H   = r_sel_h;
    assign cs      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_fullcalc_cu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fullcalc_cu
//  Description : Self-checking bench for fullcalc_cu; a transaction-level
//                model expands each operation into its expected cycle trace.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fullcalc_cu;

    localparam int MUL_LAT = 3;
    localparam int TIMEOUT = 15;

    logic       clk = 1'b0;
    logic       rst;
    logic       go;
    logic [2:0] qF;
    logic       Done_Calc;
    logic       Done_DIV;
    logic       En_F, En_X, En_Y, Go_Calc, Go_DIV;
    logic [1:0] Op_Calc, Sel_L;
    logic       Sel_H, En_out_L, En_out_H, done, err;
    logic [3:0] cs;

    fullcalc_cu #(.MUL_LAT(MUL_LAT), .TIMEOUT(TIMEOUT)) u_dut (
        .clk(clk), .rst(rst), .go(go), .qF(qF),
        .Done_Calc(Done_Calc), .Done_DIV(Done_DIV),
        .En_F(En_F), .En_X(En_X), .En_Y(En_Y),
        .Go_Calc(Go_Calc), .Go_DIV(Go_DIV), .Op_Calc(Op_Calc),
        .Sel_L(Sel_L), .Sel_H(Sel_H), .En_out_L(En_out_L), .En_out_H(En_out_H),
        .done(done), .err(err), .cs(cs)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic go; logic [2:0] qf; logic dc; logic dd; } stim_t;
    typedef struct packed {
        logic [3:0] cs;
        logic en_f, en_x, en_y, go_calc, go_div, en_l, en_h, done, err;
    } obs_t;
    typedef struct packed {
        logic op_v; logic [1:0] op; logic sl_v; logic [1:0] sl; logic sh_v; logic sh;
    } sel_t;

    stim_t stim_q[$];
    obs_t  exp_q[$];
    sel_t  sel_q[$];
    sel_t  cur_sel;
    int    errors = 0;
    int    checks = 0;

    function automatic bit rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic stim_t mk(bit g, int q, bit dc, bit dd);
        stim_t s;
        s.go = g; s.qf = 3'(q); s.dc = dc; s.dd = dd;
        return s;
    endfunction

    // Outputs implied by a cs code; wide = store also loads H.
    function automatic obs_t st(int code, bit wide);
        obs_t o;
        o = '0;
        o.cs = 4'(code);
        case (code)
            1: begin o.en_f = 1'b1; o.en_x = 1'b1; o.en_y = 1'b1; end
            3: o.go_calc = 1'b1;
            5: o.go_div  = 1'b1;
            6: begin o.en_l = 1'b1; o.en_h = wide; end
            7: o.done = 1'b1;
            8: o.err  = 1'b1;
            default: ;
        endcase
        return o;
    endfunction

    function automatic obs_t cur_obs();
        obs_t o;
        o.cs = cs; o.en_f = En_F; o.en_x = En_X; o.en_y = En_Y;
        o.go_calc = Go_Calc; o.go_div = Go_DIV; o.en_l = En_out_L;
        o.en_h = En_out_H; o.done = done; o.err = err;
        return o;
    endfunction

    task automatic push(input stim_t s, input obs_t o);
        stim_q.push_back(s);
        exp_q.push_back(o);
        sel_q.push_back(cur_sel);
    endtask

    task automatic pin(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    // n = wait cycle in which the unit reports done (0 = never).
    // lat = edges from the go-sampling edge to the first DONE/ERR cycle.
    task automatic gen_txn(input int qf, input int n, input int gap, input int hold,
                           output int lat);
        int  base, w, code;
        bit  to, wide;
        repeat (gap) push(mk(0, int'($urandom_range(0, 7)), rb(), rb()), st(0, 0));
        base = stim_q.size();
        push(mk(1, qf, rb(), rb()), st(1, 0));
        push(mk(1, qf, rb(), rb()), st(2, 0));
        wide = (qf == 5) || (qf == 6);
        cur_sel.op_v = (qf >= 1) && (qf <= 4);
        if (cur_sel.op_v) cur_sel.op = 2'(qf - 1);
        cur_sel.sl_v = (qf <= 6);
        if (cur_sel.sl_v) cur_sel.sl = (qf == 0) ? 2'd0 : (qf <= 4) ? 2'd1 : (qf == 5) ? 2'd2 : 2'd3;
        cur_sel.sh_v = wide;
        if (wide) cur_sel.sh = (qf == 6);
        code = 7;
        if (qf == 7) begin
            push(mk(1, qf, rb(), rb()), st(8, 0));
            code = 8;
        end else if (qf == 0) begin
            push(mk(1, qf, rb(), rb()), st(6, 0));
        end else if (qf == 5) begin
            repeat (MUL_LAT) push(mk(1, qf, rb(), rb()), st(4, 0));
            push(mk(1, qf, rb(), rb()), st(6, 1));
        end else begin
`ifdef FULLCALC_TIMEOUT_EN
            to = (n == 0) || (n > TIMEOUT);
            w  = to ? TIMEOUT : n;
`else
            to = 1'b0;
            w  = n;
`endif
            for (int j = 1; j <= w; j++) begin
                if (qf == 6) push(mk(1, qf, rb(), (j == 1) ? rb() : 1'b0), st(5, 0));
                else         push(mk(1, qf, (j == 1) ? rb() : 1'b0, rb()), st(3, 0));
            end
            if (to) begin
                push(mk(1, qf, (qf == 6) ? rb() : 1'b0, (qf == 6) ? 1'b0 : rb()), st(8, 0));
                code = 8;
            end else begin
                push(mk(1, qf, (qf == 6) ? rb() : 1'b1, (qf == 6) ? 1'b1 : rb()), st(6, wide));
            end
        end
        if (code == 7) push(mk(1, qf, rb(), rb()), st(7, 0));
        lat = stim_q.size() - base;
        repeat (hold) push(mk(1, qf, rb(), rb()), st(code, 0));
        push(mk(0, int'($urandom_range(0, 7)), rb(), rb()), st(0, 0));
    endtask

    initial begin
        int lat;
        obs_t a;
        rst = 1'b0; go = 1'b0; qF = 3'd0; Done_Calc = 1'b0; Done_DIV = 1'b0;
        cur_sel = '{op_v: 1'b1, op: 2'd0, sl_v: 1'b1, sl: 2'd0, sh_v: 1'b1, sh: 1'b0};

        #1;
        checks++;
        if (cur_obs() != st(0, 0) || Op_Calc != 2'd0 || Sel_L != 2'd0 || Sel_H != 1'b0) begin
            errors++;
            $display("FAIL reset_state: got %h/%0d/%0d/%0d expected %h/0/0/0",
                     cur_obs(), Op_Calc, Sel_L, Sel_H, st(0, 0));
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;

        gen_txn(1, 3, 1, 1, lat);   pin("lat_calc_add", lat, 7);
        gen_txn(5, 0, 2, 0, lat);   pin("lat_mul", lat, 7);
        gen_txn(6, 5, 0, 2, lat);   pin("lat_div_5", lat, 9);
        gen_txn(7, 0, 1, 3, lat);   pin("lat_illegal", lat, 3);
        gen_txn(0, 0, 0, 0, lat);   pin("lat_clear", lat, 4);
        gen_txn(4, 1, 2, 1, lat);   pin("lat_calc_xor_1", lat, 5);
`ifdef FULLCALC_TIMEOUT_EN
        gen_txn(6, 0, 1, 1, lat);   pin("lat_div_timeout", lat, 18);
        gen_txn(3, 15, 1, 0, lat);  pin("lat_done_beats_timeout", lat, 19);
`else
        gen_txn(6, 101, 1, 1, lat); pin("lat_div_long_wait", lat, 105);
`endif
        for (int t = 0; t < 40; t++)
            gen_txn(int'($urandom_range(0, 7)), int'($urandom_range(1, 20)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), lat);

        for (int i = 0; i < stim_q.size(); i++) begin
            @(negedge clk);
            go = stim_q[i].go; qF = stim_q[i].qf;
            Done_Calc = stim_q[i].dc; Done_DIV = stim_q[i].dd;
            @(posedge clk);
            #1;
            a = cur_obs();
            checks++;
            if (a != exp_q[i]) begin
                errors++;
                $display("FAIL cycle %0d outputs: got %h expected %h", i, a, exp_q[i]);
            end
            if (sel_q[i].op_v) begin
                checks++;
                if (Op_Calc != sel_q[i].op) begin
                    errors++;
                    $display("FAIL cycle %0d Op_Calc: got %0d expected %0d", i, Op_Calc, sel_q[i].op);
                end
            end
            if (sel_q[i].sl_v) begin
                checks++;
                if (Sel_L != sel_q[i].sl) begin
                    errors++;
                    $display("FAIL cycle %0d Sel_L: got %0d expected %0d", i, Sel_L, sel_q[i].sl);
                end
            end
            if (sel_q[i].sh_v) begin
                checks++;
                if (Sel_H != sel_q[i].sh) begin
                    errors++;
                    $display("FAIL cycle %0d Sel_H: got %0d expected %0d", i, Sel_H, sel_q[i].sh);
                end
            end
        end

        // Asynchronous reset in the middle of a DIV wait.
        @(negedge clk);
        go = 1'b1; qF = 3'd6; Done_Calc = 1'b0; Done_DIV = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        pin("mid_div_cs", int'(cs), 5);
        #2 rst = 1'b0;
        #1;
        checks++;
        if (cur_obs() != st(0, 0) || Op_Calc != 2'd0 || Sel_L != 2'd0 || Sel_H != 1'b0) begin
            errors++;
            $display("FAIL async_reset: got %h/%0d/%0d/%0d expected %h/0/0/0",
                     cur_obs(), Op_Calc, Sel_L, Sel_H, st(0, 0));
        end
        @(negedge clk) go = 1'b0;
        @(negedge clk) rst = 1'b1;

        // Clear op, then hold go in DONE: no rerun.
        @(negedge clk) go = 1'b1; qF = 3'd0;
        repeat (4) @(posedge clk);
        #1;
        pin("clear_done_cs", int'(cs), 7);
        repeat (10) @(posedge clk);
        #1;
        pin("done_hold_no_rerun", int'(cs), 7);
        pin("done_hold_done", int'(done), 1);
        @(negedge clk) go = 1'b0;
        @(posedge clk);
        #1;
        pin("done_release_idle", int'(cs), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
